// File: rtl/bisr_pkg.sv
// Shared encodings, idle levels and geometry helpers for the BISR remapper.
// Every design file that sizes storage or ports from the top-level parameters imports this package.
package bisr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_ACTIVE  = 2'd2,
      ST_FAIL    = 2'd3
   } bisr_state_e;

   // Idle levels for the macro strobes; CSB/OEB idle is all ones per bank/spare.
   localparam logic IDLE_CE    = 1'b0;
   localparam logic IDLE_WEB   = 1'b1;
   localparam logic IDLE_STB_N = 1'b1;

   function automatic int calc_nblk(input int addr_w, input int blk_aw);
      return 1 << (addr_w - blk_aw);
   endfunction

   function automatic int calc_nbank(input int addr_w, input int bank_aw);
      return 1 << (addr_w - bank_aw);
   endfunction

   function automatic int calc_siw(input int spares);
      return ($clog2(spares) < 1) ? 1 : $clog2(spares);
   endfunction

endpackage

// File: rtl/bisr_fault_table.sv
// Per-block repair table: valid/spare index storage, duplicate filter,
// spare allocation counter and sticky overflow flag, with one host lookup port.
module bisr_fault_table
   import bisr_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int BLK_AW = 7,
   parameter int SPARES = 25,
   localparam int SIW   = calc_siw(SPARES),
   localparam int BW    = ADDR_W - BLK_AW
)(
   input  logic           CLK,
   input  logic           RSTN,
   input  logic           cap_en,
   input  logic [BW-1:0]  cap_blk,
   input  logic           clr,
   input  logic [BW-1:0]  lk_blk,
   output logic           lk_hit,
   output logic [SIW-1:0] lk_idx,
   output logic           cap_alloc,
   output logic           cap_over,
   output logic [SIW:0]   fault_count,
   output logic           bisr_un
);

   localparam int NBLK = calc_nblk(ADDR_W, BLK_AW);
   localparam logic [SIW:0] SPARES_C = (SIW + 1)'(SPARES);

   logic [NBLK-1:0] valid_q;
   logic [SIW-1:0]  idx_q [NBLK];
   logic            full;

   // Counter never passes SPARES, so equality is the saturation test.
   assign full      = (fault_count == SPARES_C);
   assign cap_alloc = cap_en & ~valid_q[cap_blk] & ~full;
   assign cap_over  = cap_en & ~valid_q[cap_blk] & full;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         valid_q     <= '0;
         fault_count <= '0;
         bisr_un     <= 1'b0;
      end else if (clr) begin
         valid_q     <= '0;
         fault_count <= '0;
         bisr_un     <= 1'b0;
      end else begin
         if (cap_alloc) begin
            valid_q[cap_blk] <= 1'b1;
            fault_count      <= fault_count + 1'b1;
         end
         if (cap_over) begin
            bisr_un <= 1'b1;
         end
      end
   end

   // Index storage is qualified by valid_q, so it needs no reset.
   always_ff @(posedge CLK) begin
      if (cap_alloc) begin
         idx_q[cap_blk] <= fault_count[SIW-1:0];
      end
   end

   assign lk_hit = valid_q[lk_blk];
   assign lk_idx = lk_hit ? idx_q[lk_blk] : '0;

endmodule

// File: rtl/bisr_remap.sv
// Built-in self-repair remapper: captures BIST faults into a spare table and
// steers host accesses to the owning main bank or allocated spare, registered.
module bisr_remap
   import bisr_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 8,
   parameter int BLK_AW  = 7,
   parameter int BANK_AW = 10,
   parameter int SPARES  = 25,
   localparam int NBANK  = calc_nbank(ADDR_W, BANK_AW),
   localparam int SIW    = calc_siw(SPARES),
   localparam int SEL_W  = ADDR_W - BANK_AW
)(
   input  logic              CLK,
   input  logic              RSTN,
   input  logic              BIST_EN,
   input  logic              FAULT_VALID,
   input  logic [ADDR_W-1:0] FAULT_ADDR,
   input  logic              CLEAR,
   input  logic              REPAIR_EN,
   input  logic              CE,
   input  logic              CSB,
   input  logic              WEB,
   input  logic              OEB,
   input  logic [ADDR_W-1:0] ADDR,
   input  logic [DATA_W-1:0] IDATA,
   output logic [BANK_AW-1:0] MEM_ADDR,
   output logic               MEM_CE,
   output logic               MEM_WEB,
   output logic [NBANK-1:0]   MEM_CSB,
   output logic [NBANK-1:0]   MEM_OEB,
   output logic [DATA_W-1:0]  MEM_IDATA,
   output logic [SEL_W-1:0]   MEM_ODATA_SELECT,
   output logic [BLK_AW-1:0]  SPARE_ADDR,
   output logic               SPARE_CE,
   output logic               SPARE_WEB,
   output logic [SPARES-1:0]  SPARE_CSB,
   output logic [SPARES-1:0]  SPARE_OEB,
   output logic [DATA_W-1:0]  SPARE_IDATA,
   output logic [SIW-1:0]     SPARE_ODATA_SELECT,
   output logic [SIW:0]       FAULT_COUNT,
   output logic               BISR_UN,
   output logic [1:0]         STATE
);

   bisr_state_e state_q, state_d;

   logic           cap_en, clr, lk_hit, cap_alloc, cap_over;
   logic [SIW-1:0] lk_idx;
   logic [SEL_W-1:0] bank_k;
   logic           unused_fault_lsb;

   assign cap_en = (state_q == ST_CAPTURE) & FAULT_VALID;
   assign clr    = CLEAR & ~BIST_EN;
   assign bank_k = ADDR[ADDR_W-1:BANK_AW];
   assign unused_fault_lsb = ^FAULT_ADDR[BLK_AW-1:0];

   bisr_fault_table #(
      .ADDR_W (ADDR_W),
      .BLK_AW (BLK_AW),
      .SPARES (SPARES)
   ) u_table (
      .CLK         (CLK),
      .RSTN        (RSTN),
      .cap_en      (cap_en),
      .cap_blk     (FAULT_ADDR[ADDR_W-1:BLK_AW]),
      .clr         (clr),
      .lk_blk      (ADDR[ADDR_W-1:BLK_AW]),
      .lk_hit      (lk_hit),
      .lk_idx      (lk_idx),
      .cap_alloc   (cap_alloc),
      .cap_over    (cap_over),
      .fault_count (FAULT_COUNT),
      .bisr_un     (BISR_UN)
   );

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Leaving CAPTURE also counts a fault captured on the BIST_EN falling cycle.
   always_comb begin
      state_d = state_q;
      if (BIST_EN) begin
         state_d = ST_CAPTURE;
      end else begin
         case (state_q)
            ST_CAPTURE: begin
               if (clr)                                  state_d = ST_IDLE;
               else if (BISR_UN | cap_over)              state_d = ST_FAIL;
               else if ((FAULT_COUNT != '0) | cap_alloc) state_d = ST_ACTIVE;
               else                                      state_d = ST_IDLE;
            end
            ST_ACTIVE, ST_FAIL: if (clr) state_d = ST_IDLE;
            default: ;
         endcase
      end
   end

   assign STATE = state_q;

   logic [BANK_AW-1:0] mem_addr_d;
   logic               mem_ce_d, mem_web_d, spare_ce_d, spare_web_d;
   logic [NBANK-1:0]   mem_csb_d, mem_oeb_d;
   logic [DATA_W-1:0]  mem_idata_d, spare_idata_d;
   logic [SEL_W-1:0]   mem_sel_d;
   logic [BLK_AW-1:0]  spare_addr_d;
   logic [SPARES-1:0]  spare_csb_d, spare_oeb_d;
   logic [SIW-1:0]     spare_sel_d;

   always_comb begin
      mem_addr_d    = '0;
      mem_ce_d      = IDLE_CE;
      mem_web_d     = IDLE_WEB;
      mem_csb_d     = {NBANK{IDLE_STB_N}};
      mem_oeb_d     = {NBANK{IDLE_STB_N}};
      mem_idata_d   = '0;
      mem_sel_d     = '0;
      spare_addr_d  = '0;
      spare_ce_d    = IDLE_CE;
      spare_web_d   = IDLE_WEB;
      spare_csb_d   = {SPARES{IDLE_STB_N}};
      spare_oeb_d   = {SPARES{IDLE_STB_N}};
      spare_idata_d = '0;
      spare_sel_d   = '0;
      if (!BIST_EN) begin
         if (REPAIR_EN && lk_hit) begin
            spare_addr_d  = ADDR[BLK_AW-1:0];
            spare_ce_d    = CE;
            spare_web_d   = WEB;
            spare_idata_d = IDATA;
            spare_csb_d   = {SPARES{CSB}} | ~(SPARES'(1) << lk_idx);
            spare_oeb_d   = {SPARES{OEB}} | ~(SPARES'(1) << lk_idx);
            spare_sel_d   = lk_idx;
         end else begin
            mem_addr_d  = ADDR[BANK_AW-1:0];
            mem_ce_d    = CE;
            mem_web_d   = WEB;
            mem_idata_d = IDATA;
            mem_csb_d   = {NBANK{CSB}} | ~(NBANK'(1) << bank_k);
            mem_oeb_d   = {NBANK{OEB}} | ~(NBANK'(1) << bank_k);
            mem_sel_d   = bank_k;
         end
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         MEM_ADDR           <= '0;
         MEM_CE             <= IDLE_CE;
         MEM_WEB            <= IDLE_WEB;
         MEM_CSB            <= {NBANK{IDLE_STB_N}};
         MEM_OEB            <= {NBANK{IDLE_STB_N}};
         MEM_IDATA          <= '0;
         MEM_ODATA_SELECT   <= '0;
         SPARE_ADDR         <= '0;
         SPARE_CE           <= IDLE_CE;
         SPARE_WEB          <= IDLE_WEB;
         SPARE_CSB          <= {SPARES{IDLE_STB_N}};
         SPARE_OEB          <= {SPARES{IDLE_STB_N}};
         SPARE_IDATA        <= '0;
         SPARE_ODATA_SELECT <= '0;
      end else begin
         MEM_ADDR           <= mem_addr_d;
         MEM_CE             <= mem_ce_d;
         MEM_WEB            <= mem_web_d;
         MEM_CSB            <= mem_csb_d;
         MEM_OEB            <= mem_oeb_d;
         MEM_IDATA          <= mem_idata_d;
         MEM_ODATA_SELECT   <= mem_sel_d;
         SPARE_ADDR         <= spare_addr_d;
         SPARE_CE           <= spare_ce_d;
         SPARE_WEB          <= spare_web_d;
         SPARE_CSB          <= spare_csb_d;
         SPARE_OEB          <= spare_oeb_d;
         SPARE_IDATA        <= spare_idata_d;
         SPARE_ODATA_SELECT <= spare_sel_d;
      end
   end

endmodule
